// File: rtl/rcvr_pkg.sv
// Shared constants and helpers for the serial frame receiver.
package rcvr_pkg;

    // Receiver FSM encoding, kept as plain constants for older tooling.
    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    // Ceiling log2 for sizing counters and pointers; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rcvr_fifo.sv
// Synchronous first-word-fall-through FIFO. A push on a full FIFO is
// accepted only when a pop happens in the same cycle; a pop on an empty
// FIFO is ignored. Occupancy is tracked separately from the pointers so
// full and empty stay distinct.
module rcvr_fifo
    import rcvr_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DW-1:0]         push_data,
    input  logic                  pop,
    output logic [DW-1:0]         pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];
    assign count    = cnt;

    // Storage write; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/serial_frame_rcvr.sv
// Bit-serial frame receiver: hunts for a header pattern, captures a
// DATA_W-bit payload and queues it in an FWFT FIFO.
// Read handshake: rd_valid high means rd_data holds the head word; a cycle
// with rd_valid && rd_en pops it at the rising edge. rd_en with rd_valid
// low has no effect.
module serial_frame_rcvr
    import rcvr_pkg::*;
#(
    parameter int               HDR_W     = 8,
    parameter logic [HDR_W-1:0] HDR       = 8'hA5,
    parameter int               DATA_W    = 8,
    parameter int               DEPTH     = 4,
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bit_en,
    input  logic                  data_in,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic [clog2(DEPTH):0] count,
    output logic                  overrun,
    input  logic                  ovr_clr,
    output logic                  in_frame
);

    localparam int FILL_W = clog2(HDR_W + 1);
    localparam int BC_W   = clog2(DATA_W) + 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(HDR_W);
    localparam logic [BC_W-1:0]   BIT_LAST = BC_W'(DATA_W - 1);

    logic [0:0]        state;
    logic [HDR_W-1:0]  hdr_sr;
    logic [HDR_W-1:0]  hdr_next;
    logic [FILL_W-1:0] fill;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] payload;
    logic [DATA_W-1:0] word_next;
    logic              hdr_match;
    logic              last_bit;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    // Header window including the bit being sampled now; the fill guard
    // keeps stale or reset contents from producing a match.
    assign hdr_next  = HDR_W'({hdr_sr, data_in});
    assign hdr_match = (fill >= FILL_MAX - 1'b1) && (hdr_next == HDR);

    // Payload including the current bit, in the configured bit order.
    assign word_next = MSB_FIRST ? DATA_W'({payload, data_in})
                                 : DATA_W'({data_in, payload} >> 1);

    assign last_bit = bit_en && (state == ST_BODY) && (bit_cnt == BIT_LAST);
    assign push     = last_bit;
    assign pop      = rd_en && !fifo_empty;
    assign rd_valid = !fifo_empty;
    assign in_frame = (state == ST_BODY);

    // Frame FSM with header hunt, fill count and payload bit counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_HUNT;
            fill    <= '0;
            bit_cnt <= '0;
        end else if (bit_en) begin
            if (state == ST_HUNT) begin
                if (hdr_match) begin
                    state   <= ST_BODY;
                    bit_cnt <= '0;
                    fill    <= '0;
                end else if (fill < FILL_MAX) begin
                    fill <= fill + 1'b1;
                end
            end else begin
                if (last_bit) begin
                    state <= ST_HUNT;
                    fill  <= '0;
                end
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Shift registers carry no control meaning, so they are not reset.
    always_ff @(posedge clock) begin
        if (bit_en) begin
            if (state == ST_HUNT) begin
                hdr_sr <= hdr_next;
            end else begin
                payload <= word_next;
            end
        end
    end

    // Sticky overrun: a drop sets it and wins over a same-cycle clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    rcvr_fifo #(
        .DW    (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (word_next),
        .pop       (pop),
        .pop_data  (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

endmodule

// File: tb/tb_serial_frame_rcvr.sv
// Self-checking bench for serial_frame_rcvr: default 8-bit instance plus a
// 12-bit LSB-first instance with a 4-bit header.
module tb_serial_frame_rcvr;

    logic        clock = 1'b0;
    logic        reset;

    logic        bit_en, data_in, rd_en, ovr_clr;
    logic [7:0]  rd_data;
    logic        rd_valid, overrun, in_frame;
    logic [2:0]  count;

    logic        bit_en7, data_in7, rd_en7, ovr_clr7;
    logic [11:0] rd_data7;
    logic        rd_valid7, overrun7, in_frame7;
    logic [2:0]  count7;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]  exp_q[$];
    logic [11:0] exp_q7[$];

    always #5 clock = ~clock;

    serial_frame_rcvr u_dut (
        .clock    (clock),
        .reset    (reset),
        .bit_en   (bit_en),
        .data_in  (data_in),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr),
        .in_frame (in_frame)
    );

    serial_frame_rcvr #(
        .HDR_W     (4),
        .HDR       (4'hB),
        .DATA_W    (12),
        .DEPTH     (4),
        .MSB_FIRST (1'b0)
    ) u_dut7 (
        .clock    (clock),
        .reset    (reset),
        .bit_en   (bit_en7),
        .data_in  (data_in7),
        .rd_en    (rd_en7),
        .rd_data  (rd_data7),
        .rd_valid (rd_valid7),
        .count    (count7),
        .overrun  (overrun7),
        .ovr_clr  (ovr_clr7),
        .in_frame (in_frame7)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_q7.delete();
    endtask

    task automatic send_bit(input logic b);
        bit_en  = 1'b1;
        data_in = b;
        tick();
        bit_en  = 1'b0;
        data_in = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [7:0] v);
        send_byte(8'hA5);
        send_byte(v);
    endtask

    task automatic send_bit_slow(input logic b);
        for (int i = 0; i < 2; i++) begin
            data_in = ~data_in;
            tick();
        end
        send_bit(b);
    endtask

    task automatic send7_bit(input logic b);
        bit_en7  = 1'b1;
        data_in7 = b;
        tick();
        bit_en7  = 1'b0;
        data_in7 = 1'($urandom_range(0, 1));
    endtask

    // Pop one word from the default instance; returns what was presented.
    task automatic pop_word(output logic [7:0] d, output logic v);
        v     = rd_valid;
        d     = rd_data;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pop_word7(output logic [11:0] d, output logic v);
        v      = rd_valid7;
        d      = rd_data7;
        rd_en7 = 1'b1;
        tick();
        rd_en7 = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        compared++;
        if (rd_valid !== 1'b0 || count !== 3'd0 || overrun !== 1'b0 || in_frame !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: rd_valid=%b count=%0d overrun=%b in_frame=%b, required 0/0/0/0",
                     rd_valid, count, overrun, in_frame);
        end
        compared++;
        if (rd_valid7 !== 1'b0 || count7 !== 3'd0 || overrun7 !== 1'b0 || in_frame7 !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state7: rd_valid=%b count=%0d overrun=%b in_frame=%b, required 0/0/0/0",
                     rd_valid7, count7, overrun7, in_frame7);
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] d, e;
        logic       v;
        logic [7:0] pay;
        pay = 8'h3C;
        exp_q.push_back(pay);
        send_byte(8'hA5);
        compared++;
        if (in_frame !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_in_frame: in_frame=%b, required 1", in_frame);
        end
        for (int i = 7; i >= 1; i--) send_bit(pay[i]);
        compared++;
        if (rd_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_early_valid: rd_valid=%b before last bit, required 0", rd_valid);
        end
        send_bit(pay[0]);
        compared++;
        if (rd_valid !== 1'b1 || count !== 3'd1 || in_frame !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_latency: rd_valid=%b count=%0d in_frame=%b, required 1/1/0",
                     rd_valid, count, in_frame);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_word(d, v);
            compared++;
            if (v !== 1'b1 || d !== e) begin
                mismatched++;
                $display("FAIL basic_data: got %h valid=%b, required %h", d, v, e);
            end
        end
        compared++;
        if (rd_valid !== 1'b0 || count !== 3'd0) begin
            mismatched++;
            $display("FAIL basic_empty: rd_valid=%b count=%0d, required 0/0", rd_valid, count);
        end
    endtask

    task automatic test_overlap_header();
        logic [7:0] d, e;
        logic       v;
        logic [3:0] prefix;
        prefix = 4'b1010;
        for (int i = 3; i >= 0; i--) send_bit(prefix[i]);
        send_byte(8'hA5);
        exp_q.push_back(8'h81);
        send_byte(8'h81);
        compared++;
        if (count !== 3'd1) begin
            mismatched++;
            $display("FAIL overlap_count: count=%0d, required 1", count);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_word(d, v);
            compared++;
            if (v !== 1'b1 || d !== e) begin
                mismatched++;
                $display("FAIL overlap_data: got %h valid=%b, required %h", d, v, e);
            end
        end
    endtask

    task automatic test_sparse_strobe();
        logic [7:0] d, e;
        logic       v;
        logic [15:0] frame;
        frame = 16'hA55A;
        exp_q.push_back(frame[7:0]);
        for (int i = 15; i >= 0; i--) send_bit_slow(frame[i]);
        compared++;
        if (count !== 3'd1) begin
            mismatched++;
            $display("FAIL sparse_count: count=%0d, required 1", count);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_word(d, v);
            compared++;
            if (v !== 1'b1 || d !== e) begin
                mismatched++;
                $display("FAIL sparse_data: got %h valid=%b, required %h", d, v, e);
            end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d, e;
        logic       v;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_q.push_back(8'(k));
            // Clear held through the dropping frame: the set must win.
            if (k == 5) ovr_clr = 1'b1;
            send_frame(8'(k));
            ovr_clr = 1'b0;
            if (k == 4) begin
                compared++;
                if (overrun !== 1'b0 || count !== 3'd4) begin
                    mismatched++;
                    $display("FAIL ovr_at_full: overrun=%b count=%0d, required 0/4", overrun, count);
                end
            end
        end
        compared++;
        if (overrun !== 1'b1 || count !== 3'd4) begin
            mismatched++;
            $display("FAIL ovr_drop: overrun=%b count=%0d, required 1/4", overrun, count);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_word(d, v);
            compared++;
            if (v !== 1'b1 || d !== e) begin
                mismatched++;
                $display("FAIL ovr_data: got %h valid=%b, required %h", d, v, e);
            end
        end
        compared++;
        if (overrun !== 1'b1 || rd_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL ovr_sticky: overrun=%b rd_valid=%b, required 1/0", overrun, rd_valid);
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        compared++;
        if (overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL ovr_clear: overrun=%b, required 0", overrun);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d, e;
        logic       v;
        logic [7:0] pay;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(8'(k));
            send_frame(8'(k));
        end
        pay = 8'h06;
        send_byte(8'hA5);
        for (int i = 7; i >= 1; i--) send_bit(pay[i]);
        // Last payload bit and pop share one cycle on a full FIFO.
        d       = rd_data;
        v       = rd_valid;
        rd_en   = 1'b1;
        bit_en  = 1'b1;
        data_in = pay[0];
        tick();
        rd_en   = 1'b0;
        bit_en  = 1'b0;
        e = exp_q.pop_front();
        exp_q.push_back(pay);
        compared++;
        if (v !== 1'b1 || d !== e) begin
            mismatched++;
            $display("FAIL fullpp_pop: got %h valid=%b, required %h", d, v, e);
        end
        compared++;
        if (overrun !== 1'b0 || count !== 3'd4) begin
            mismatched++;
            $display("FAIL fullpp_state: overrun=%b count=%0d, required 0/4", overrun, count);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_word(d, v);
            compared++;
            if (v !== 1'b1 || d !== e) begin
                mismatched++;
                $display("FAIL fullpp_data: got %h valid=%b, required %h", d, v, e);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [7:0] d, e;
        logic       v;
        exp_q.push_back(8'h11);
        send_frame(8'h11);
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        compared++;
        if (in_frame !== 1'b1) begin
            mismatched++;
            $display("FAIL midrst_in_frame: in_frame=%b, required 1", in_frame);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        compared++;
        if (in_frame !== 1'b0 || count !== 3'd0 || rd_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_state: in_frame=%b count=%0d rd_valid=%b, required 0/0/0",
                     in_frame, count, rd_valid);
        end
        exp_q.push_back(8'h77);
        send_frame(8'h77);
        compared++;
        if (count !== 3'd1) begin
            mismatched++;
            $display("FAIL midrst_count: count=%0d, required 1", count);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_word(d, v);
            compared++;
            if (v !== 1'b1 || d !== e) begin
                mismatched++;
                $display("FAIL midrst_data: got %h valid=%b, required %h", d, v, e);
            end
        end
    endtask

    task automatic test_lsb_first();
        logic [11:0] d, e;
        logic        v;
        logic [3:0]  hdr;
        logic [11:0] words [2];
        hdr      = 4'b1011;
        words[0] = 12'h001;
        words[1] = 12'h8C3;
        for (int w = 0; w < 2; w++) begin
            exp_q7.push_back(words[w]);
            for (int i = 3; i >= 0; i--) send7_bit(hdr[i]);
            for (int i = 0; i < 12; i++) send7_bit(words[w][i]);
        end
        compared++;
        if (count7 !== 3'd2 || in_frame7 !== 1'b0) begin
            mismatched++;
            $display("FAIL lsb_count: count=%0d in_frame=%b, required 2/0", count7, in_frame7);
        end
        while (exp_q7.size() > 0) begin
            e = exp_q7.pop_front();
            pop_word7(d, v);
            compared++;
            if (v !== 1'b1 || d !== e) begin
                mismatched++;
                $display("FAIL lsb_data: got %h valid=%b, required %h", d, v, e);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset    = 1'b1;
        bit_en   = 1'b0;
        data_in  = 1'b0;
        rd_en    = 1'b0;
        ovr_clr  = 1'b0;
        bit_en7  = 1'b0;
        data_in7 = 1'b0;
        rd_en7   = 1'b0;
        ovr_clr7 = 1'b0;

        test_reset();
        test_basic_frame();
        test_overlap_header();
        test_sparse_strobe();
        test_overrun();
        test_full_push_pop();
        test_mid_frame_reset();
        test_lsb_first();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
